// File: rtl/iso7816_pkg.sv
// Shared definitions for the ISO7816 receive character buffer.
// Contents: receive FSM state encoding, default ETU counter width,
// default CWT width, and a helper that maps a clocksPerBit of 0 to 1.
package iso7816_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_WAITCLR = 2'd2
  } rx_state_e;

  localparam int ETU_W      = 13;
  localparam int WAIT_W_DEF = 16;

  // A zero-length ETU would stall the watchdog, so 0 behaves like 1.
  function automatic logic [ETU_W-1:0] etu_len(input logic [ETU_W-1:0] cpb);
    return (cpb == '0) ? {{(ETU_W-1){1'b0}}, 1'b1} : cpb;
  endfunction

endpackage

// File: rtl/rx_byte_fifo.sv
// Synchronous byte FIFO, depth 2**ADDR_W, registered pointers.
// Ports:
//   clk, nReset        clock, async active-low reset
//   push, push_data    write request and byte
//   pop                read request (ignored when empty)
//   out_data/out_valid head of queue, valid when not empty (0 when empty)
//   full, count        occupancy status
//   drop               pulse: push refused because full with no pop
module rx_byte_fifo #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              nReset,
  input  logic              push,
  input  logic [7:0]        push_data,
  input  logic              pop,
  output logic [7:0]        out_data,
  output logic              out_valid,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              drop
);

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  logic [7:0]        mem_q [2**ADDR_W];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              empty;
  logic              pop_ok;
  logic              push_ok;

  always_comb begin
    empty   = (count_q == '0);
    full    = (count_q == DEPTH);
    pop_ok  = pop && !empty;
    // A same-cycle pop frees the slot, so a push into a full FIFO still lands.
    push_ok = push && (!full || pop_ok);
    drop    = push && full && !pop_ok;

    wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop_ok  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (push_ok && !pop_ok) count_d = count_q + 1'b1;
    if (pop_ok && !push_ok) count_d = count_q - 1'b1;

    out_valid = !empty;
    out_data  = empty ? 8'h00 : mem_q[rd_ptr_q];
    count     = count_q;
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: out_data is masked while empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/iso7816_rx_char_buffer.sv
// Receive-side consumer of the half-duplex UART character engine.
// Acknowledges each completed character, queues good bytes, counts
// frame errors, tracks overrun/overflow, and runs the CWT watchdog.
// Ports:
//   clk, nReset                       clock, async active-low reset
//   uartRxData/DataReady/FrameError/Overrun/RxStartBit/IsTx  UART status
//   uartAckFlags                      one-cycle ack to the UART
//   clocksPerBit, waitEtus            ETU length and CWT limit (0 = off)
//   popData, outData, outValid, fifoFull, fifoCount   FIFO consumer side
//   errCount, overflowFlag, overrunFlag, timeoutFlag  status, clearFlags clears
//
// state      | meaning
// -----------+-----------------------------------------------
// ST_IDLE    | waiting for uartDataReady
// ST_CAPTURE | sample byte/flags, push or count error; ack high
// ST_WAITCLR | waiting for the UART to drop uartDataReady
module iso7816_rx_char_buffer
  import iso7816_pkg::*;
#(
  parameter int ADDR_W   = 4,
  parameter int ERRCNT_W = 8,
  parameter int WAIT_W   = WAIT_W_DEF
) (
  input  logic                clk,
  input  logic                nReset,
  input  logic [7:0]          uartRxData,
  input  logic                uartDataReady,
  input  logic                uartFrameError,
  input  logic                uartOverrun,
  input  logic                uartRxStartBit,
  input  logic                uartIsTx,
  output logic                uartAckFlags,
  input  logic [ETU_W-1:0]    clocksPerBit,
  input  logic [WAIT_W-1:0]   waitEtus,
  input  logic                popData,
  output logic [7:0]          outData,
  output logic                outValid,
  output logic                fifoFull,
  output logic [ADDR_W:0]     fifoCount,
  output logic [ERRCNT_W-1:0] errCount,
  output logic                overflowFlag,
  output logic                overrunFlag,
  output logic                timeoutFlag,
  input  logic                clearFlags
);

  rx_state_e           state_q, state_d;
  logic                ack_q, ack_d;
  logic [ERRCNT_W-1:0] err_cnt_q, err_cnt_d;
  logic                ovf_q, ovf_d;
  logic                ovr_q, ovr_d;
  logic                to_q, to_d;
  logic                start_q, start_d;
  logic [ETU_W-1:0]    clk_cnt_q, clk_cnt_d;
  logic [WAIT_W-1:0]   etu_cnt_q, etu_cnt_d;

  logic                push_en;
  logic                err_inc;
  logic                fifo_drop;
  logic [ETU_W-1:0]    cpb_eff;
  logic                wd_clear;
  logic                to_set;

  // FSM: state register
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (uartDataReady) state_d = ST_CAPTURE;
      ST_CAPTURE: state_d = ST_WAITCLR;
      ST_WAITCLR: if (!uartDataReady) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs. The ack is registered from the IDLE->CAPTURE decision so
  // it is high exactly during the CAPTURE cycle.
  always_comb begin
    ack_d   = (state_q == ST_IDLE) && uartDataReady;
    push_en = (state_q == ST_CAPTURE) && !uartFrameError;
    err_inc = (state_q == ST_CAPTURE) && uartFrameError;
  end

  rx_byte_fifo #(.ADDR_W(ADDR_W)) u_fifo (
    .clk       (clk),
    .nReset    (nReset),
    .push      (push_en),
    .push_data (uartRxData),
    .pop       (popData),
    .out_data  (outData),
    .out_valid (outValid),
    .full      (fifoFull),
    .count     (fifoCount),
    .drop      (fifo_drop)
  );

  // Status flags and CWT watchdog
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (clearFlags)                      err_cnt_d = '0;
    else if (err_inc && err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;

    ovf_d   = clearFlags ? 1'b0 : (ovf_q | fifo_drop);
    ovr_d   = clearFlags ? 1'b0 : (ovr_q | uartOverrun);
    start_d = uartRxStartBit;

    cpb_eff  = etu_len(clocksPerBit);
    wd_clear = (uartRxStartBit && !start_q) || uartIsTx || (waitEtus == '0);

    clk_cnt_d = clk_cnt_q + 1'b1;
    etu_cnt_d = etu_cnt_q;
    if (wd_clear) begin
      clk_cnt_d = '0;
      etu_cnt_d = '0;
    end else if (clk_cnt_q >= cpb_eff - 1'b1) begin
      clk_cnt_d = '0;
      if (etu_cnt_q != '1) etu_cnt_d = etu_cnt_q + 1'b1;
    end

    // Compare the incoming count so the flag rises on the edge that
    // completes the last ETU rather than one cycle later.
    to_set = (waitEtus != '0) && (etu_cnt_d == waitEtus);
    to_d   = clearFlags ? 1'b0 : (to_q | to_set);
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      ack_q     <= 1'b0;
      err_cnt_q <= '0;
      ovf_q     <= 1'b0;
      ovr_q     <= 1'b0;
      to_q      <= 1'b0;
      start_q   <= 1'b0;
      clk_cnt_q <= '0;
      etu_cnt_q <= '0;
    end else begin
      ack_q     <= ack_d;
      err_cnt_q <= err_cnt_d;
      ovf_q     <= ovf_d;
      ovr_q     <= ovr_d;
      to_q      <= to_d;
      start_q   <= start_d;
      clk_cnt_q <= clk_cnt_d;
      etu_cnt_q <= etu_cnt_d;
    end
  end

  assign uartAckFlags = ack_q;
  assign errCount     = err_cnt_q;
  assign overflowFlag = ovf_q;
  assign overrunFlag  = ovr_q;
  assign timeoutFlag  = to_q;

endmodule

// File: tb/tb_iso7816_rx_char_buffer.sv
module tb_iso7816_rx_char_buffer;

  localparam int ADDR_W   = 4;
  localparam int ERRCNT_W = 8;
  localparam int WAIT_W   = 16;
  localparam int DEPTH    = 16;

  logic                clk = 1'b0;
  logic                nReset;
  logic [7:0]          uartRxData;
  logic                uartDataReady;
  logic                uartFrameError;
  logic                uartOverrun;
  logic                uartRxStartBit;
  logic                uartIsTx;
  logic                uartAckFlags;
  logic [12:0]         clocksPerBit;
  logic [WAIT_W-1:0]   waitEtus;
  logic                popData;
  logic [7:0]          outData;
  logic                outValid;
  logic                fifoFull;
  logic [ADDR_W:0]     fifoCount;
  logic [ERRCNT_W-1:0] errCount;
  logic                overflowFlag;
  logic                overrunFlag;
  logic                timeoutFlag;
  logic                clearFlags;

  iso7816_rx_char_buffer #(.ADDR_W(ADDR_W), .ERRCNT_W(ERRCNT_W), .WAIT_W(WAIT_W)) dut (
    .clk            (clk),
    .nReset         (nReset),
    .uartRxData     (uartRxData),
    .uartDataReady  (uartDataReady),
    .uartFrameError (uartFrameError),
    .uartOverrun    (uartOverrun),
    .uartRxStartBit (uartRxStartBit),
    .uartIsTx       (uartIsTx),
    .uartAckFlags   (uartAckFlags),
    .clocksPerBit   (clocksPerBit),
    .waitEtus       (waitEtus),
    .popData        (popData),
    .outData        (outData),
    .outValid       (outValid),
    .fifoFull       (fifoFull),
    .fifoCount      (fifoCount),
    .errCount       (errCount),
    .overflowFlag   (overflowFlag),
    .overrunFlag    (overrunFlag),
    .timeoutFlag    (timeoutFlag),
    .clearFlags     (clearFlags)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];
  int exp_err = 0;
  int exp_ovf = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  // One UART character; optionally pop during the DUT's push cycle.
  task automatic send_char(input logic [7:0] b, input logic fe, input logic pop_on_push);
    bit seen;
    int lat;
    @(negedge clk);
    uartRxData = b; uartFrameError = fe; uartDataReady = 1'b1;
    seen = 0; lat = 0;
    for (int i = 1; i <= 8 && !seen; i++) begin
      @(posedge clk); #1;
      if (uartAckFlags) begin seen = 1; lat = i; end
    end
    check("ack_seen", 32'(seen), 1);
    if (!seen) begin uartDataReady = 1'b0; return; end
    check("ack_latency", lat, 1);
    if (pop_on_push && exp_q.size() > 0) begin
      check("pop_push_head", outData, exp_q.pop_front());
      popData = 1'b1;
    end
    if (fe) begin
      if (exp_err < 255) exp_err++;
    end else if (exp_q.size() < DEPTH) exp_q.push_back(b);
    else exp_ovf = 1;
    @(posedge clk); #1;
    popData = 1'b0;
    check("ack_one_cycle", uartAckFlags, 0);
    uartDataReady = 1'b0; uartFrameError = 1'b0;
    check("count", fifoCount, exp_q.size());
    check("err_count", errCount, exp_err);
    check("overflow", overflowFlag, exp_ovf);
    if (exp_q.size() > 0) check("head", outData, exp_q[0]);
    @(posedge clk); #1;
  endtask

  task automatic pop_one();
    @(negedge clk);
    if (exp_q.size() > 0) check("pop_head", outData, exp_q.pop_front());
    popData = 1'b1;
    @(posedge clk); #1;
    popData = 1'b0;
    check("pop_count", fifoCount, exp_q.size());
  endtask

  task automatic pulse_clear();
    @(negedge clk); clearFlags = 1'b1;
    @(negedge clk); clearFlags = 1'b0;
    exp_err = 0; exp_ovf = 0;
  endtask

  initial begin
    nReset = 1'b0; uartRxData = 8'h00; uartDataReady = 1'b0; uartFrameError = 1'b0;
    uartOverrun = 1'b0; uartRxStartBit = 1'b0; uartIsTx = 1'b0; clocksPerBit = 13'd372;
    waitEtus = '0; popData = 1'b0; clearFlags = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", outValid, 0);
    check("rst_count", fifoCount, 0);
    check("rst_ack", uartAckFlags, 0);
    check("rst_flags", {errCount, overflowFlag, overrunFlag, timeoutFlag, fifoFull}, 0);
    @(negedge clk); nReset = 1'b1;

    // single byte, then pop to empty
    send_char(8'hA5, 1'b0, 1'b0);
    check("single_valid", outValid, 1);
    check("single_data", outData, 8'hA5);
    pop_one();
    check("single_empty", outValid, 0);

    // pop while empty is ignored
    @(negedge clk); popData = 1'b1;
    @(posedge clk); #1; popData = 1'b0;
    check("empty_pop_count", fifoCount, 0);
    check("empty_pop_valid", outValid, 0);

    // frame error
    send_char(8'h3B, 1'b1, 1'b0);
    check("fe_no_push", outValid, 0);
    pulse_clear();
    check("fe_cleared", errCount, 0);

    // overflow
    for (int i = 0; i < 17; i++) begin
      send_char(8'h10 + 8'(i), 1'b0, 1'b0);
      if (i == 15) check("full_at_16", fifoFull, 1);
    end
    check("ovf_flag", overflowFlag, 1);
    check("ovf_head", outData, 8'h10);
    check("ovf_count", fifoCount, 16);
    pulse_clear();
    check("ovf_cleared", overflowFlag, 0);
    check("clear_no_flush", fifoCount, 16);

    // full with pop on every push cycle, crossing the pointer wrap
    for (int i = 0; i < 20; i++) send_char(8'h40 + 8'(i), 1'b0, 1'b1);
    check("popfull_count", fifoCount, 16);
    check("popfull_ovf", overflowFlag, 0);
    for (int i = 0; i < 16; i++) pop_one();
    check("drained", outValid, 0);

    // overrun, and clear beating a same-cycle set
    @(negedge clk); uartOverrun = 1'b1;
    @(posedge clk); #1; check("overrun_set", overrunFlag, 1);
    @(negedge clk); clearFlags = 1'b1;
    @(posedge clk); #1; check("overrun_clear_prio", overrunFlag, 0);
    @(negedge clk); uartOverrun = 1'b0; clearFlags = 1'b0;

    // CWT watchdog
    @(negedge clk); uartIsTx = 1'b1; waitEtus = 16'd3; clocksPerBit = 13'd10; clearFlags = 1'b1;
    @(negedge clk); clearFlags = 1'b0; uartIsTx = 1'b0; uartRxStartBit = 1'b1;
    @(posedge clk); #1;
    @(negedge clk); uartRxStartBit = 1'b0;
    for (int i = 1; i < 30; i++) begin @(posedge clk); #1; end
    check("cwt_early", timeoutFlag, 0);
    @(posedge clk); #1;
    check("cwt_fire", timeoutFlag, 1);
    @(negedge clk); clearFlags = 1'b1;
    @(posedge clk); #1; check("cwt_clear_prio", timeoutFlag, 0);
    @(negedge clk); clearFlags = 1'b0; uartIsTx = 1'b1;
    repeat (100) @(posedge clk);
    #1; check("cwt_tx_hold", timeoutFlag, 0);
    @(negedge clk); uartIsTx = 1'b0; waitEtus = '0; clocksPerBit = 13'd372;

    // reset in the middle of CAPTURE with state present
    send_char(8'h77, 1'b0, 1'b0);
    send_char(8'h66, 1'b1, 1'b0);
    @(negedge clk); uartRxData = 8'h5C; uartDataReady = 1'b1;
    @(posedge clk); #1;
    check("pre_rst_ack", uartAckFlags, 1);
    #1 nReset = 1'b0;
    #1;
    check("midrst_ack", uartAckFlags, 0);
    check("midrst_valid", outValid, 0);
    check("midrst_count", fifoCount, 0);
    check("midrst_err", errCount, 0);
    exp_q.delete(); exp_err = 0;
    @(negedge clk); nReset = 1'b1;
    begin
      int acks = 0;
      bit dropped = 0;
      for (int i = 0; i < 8; i++) begin
        @(posedge clk); #1;
        if (uartAckFlags) acks++;
        else if (acks > 0 && !dropped) begin uartDataReady = 1'b0; dropped = 1; end
      end
      uartDataReady = 1'b0;
      check("post_rst_acks", acks, 1);
    end
    exp_q.push_back(8'h5C);
    check("post_rst_count", fifoCount, exp_q.size());
    check("post_rst_head", outData, exp_q[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
